duck_motion: RTL and testbench
==============================

# duck_motion

Parametrised flight controller for one on-screen duck. It launches a duck on request and moves it once per video frame, bouncing off configurable screen limits. It handles a hit (freeze, then fall to the floor) or an escape after a frame timeout (fly off the top), then reports completion. It sits between the game controller (launch and speed selection, hit detection) and the duck sprite renderer (position, visibility, pose).

## Interface
- `X_MAX`, default 1024: screen width; x limit is `X_MAX-1`.
- `Y_FLOOR`, default 600: lower y bounce and landing limit; also the launch y.
- `POS_W`, default 11: position width.
- `SPD_W`, default 5: speed input width.
- `DEFAULT_V_SPD`, default 15: vertical speed used when `duck_v_spd`=0.
- `FALL_SPD`, default 8: y increment per frame while falling.
- `HIT_HOLD_FRAMES`, default 30: frames the duck freezes after a hit.
- `ESCAPE_FRAMES`, default 600: flying frames before escape.
- `FLAP_FRAMES`, default 8: frames per wing-pose toggle.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `new_frame` in 1: one-cycle pulse per video frame.
- `start` in 1: launch request; honoured only in IDLE.
- `duck_direction` in 1: initial horizontal direction; 1=right, 0=left.
- `duck_v_spd` in SPD_W: vertical speed, pixels/frame.
- `duck_h_spd` in SPD_W: horizontal speed, pixels/frame; 0 is legal.
- `duck_start_x` in POS_W: launch x.
- `hit` in 1: one-cycle pulse meaning the duck was shot.
- `duck_x`, `duck_y` out POS_W: registered position.
- `duck_show` out 1: sprite visible.
- `duck_hit` out 1: hit pose, asserted in HIT_HOLD and FALL.
- `duck_flap` out 1: wing pose.
- `done` out 1: one-cycle pulse when the sequence ends.
- `escaped` out 1: outcome of the last sequence, held until the next `start`.

## Operation
- States: IDLE, FLY, HIT_HOLD, FALL, ESCAPE, DONE.
- **IDLE** (`duck_show`=0):
  - On `start`, latch the speeds and direction, then go to FLY.
  - `v_spd` becomes `DEFAULT_V_SPD` if the input is 0.
  - x becomes `duck_start_x`, clamped to `X_MAX-1`; y becomes `Y_FLOOR`; dir_y becomes up.
  - Clear `escaped`, the frame counter and `duck_flap`.
- **FLY**, on each `new_frame`, both axes step using POS_W+1-bit arithmetic:
  - Right: if x+h > `X_MAX-1`, then x=`X_MAX-1` and dir_x flips; otherwise x+=h.
  - Left: if h > x, then x=0 and dir_x flips; otherwise x-=h.
  - Up: if v > y, then y=0 and dir_y flips to down; otherwise y-=v.
  - Down: if y+v > `Y_FLOOR`, then y=`Y_FLOOR` and dir_y flips to up; otherwise y+=v.
  - The frame counter increments. When the counter reaches `ESCAPE_FRAMES`, go to ESCAPE.
- **ESCAPE**: on each frame x holds. If v > y, go to DONE with `escaped`=1; otherwise y-=v.
- **Hit**:
  - `hit` in FLY or ESCAPE goes to HIT_HOLD and reloads the counter.
  - In HIT_HOLD, position is frozen for `HIT_HOLD_FRAMES` frames, then the state goes to FALL.
  - In FALL, y+=`FALL_SPD` per frame. If y+`FALL_SPD` ≥ `Y_FLOOR`, then y=`Y_FLOOR` and go to DONE with `escaped`=0.
  - `hit` outside FLY and ESCAPE is ignored.
- **DONE**: `done`=1 for one cycle, `duck_show`=0, then go to IDLE. x and y hold.
- `duck_show`=1 in FLY, HIT_HOLD, FALL and ESCAPE.
- `duck_flap` toggles every `FLAP_FRAMES` frames in FLY and ESCAPE; it holds otherwise.
- Simultaneous events:
  - `hit` and `new_frame` in the same cycle: hit wins and there is no movement that cycle.
  - `hit` in the cycle the escape counter expires: hit wins.
  - `start` outside IDLE is ignored.

## Timing
- Reset values: `duck_x`=0, `duck_y`=0, `duck_show`=0, `duck_hit`=0, `duck_flap`=0, `done`=0, `escaped`=0, state IDLE, counters 0.
- `rst` takes effect at the next edge from any state, including mid-FALL or mid-ESCAPE.
- All outputs are registered. `start` at edge t gives FLY and the launch position visible after t.
- The position update for a `new_frame` sampled at edge t is visible after t, i.e. one-cycle latency.
- `hit` at edge t gives `duck_hit`=1 after t.
- The DONE→IDLE transition happens one cycle after DONE is entered. Back-to-back `start` is therefore accepted two cycles after the final move.

## Structure
- Package `duck_pkg` holds:
  - the state enum typedef;
  - the default constants (`X_MAX`, `Y_FLOOR`, `DEFAULT_V_SPD`, `FALL_SPD`).
- Sub-module `duck_axis_step` computes the per-axis bounce step. Inputs are pos, spd, dir and limit; outputs are pos_nxt and dir_nxt. It is purely combinational and is instantiated for x and for y. The FALL and ESCAPE steps reuse the y instance.
- The top level contains the FSM, the shared frame counter and the flap counter.

## Test plan
- Launch test. Stimulus: reset, `start` with start_x=100, h=4, dir=1, v=0, then one `new_frame`. Required: x=100, y=600, show=1, then x=104, y=585.
- Right-wall bounce. Stimulus: x=1020, h=8 moving right, then one frame. Required: x=1023, dir left; next frame x=1015. Left wall: x=3, h=8 gives x=0, dir right.
- Top/floor bounce. Stimulus: y=10, v=15 up. Required: y=0, then down. Stimulus: y=590, v=15 down. Required: y=600, then up.
- Hit sequence. Stimulus: `hit` together with `new_frame`. Required: no move, `duck_hit`=1, position frozen for 30 frames, then y+=8 per frame to 600, `done` pulse, `escaped`=0, show=0.
- Escape sequence, with ESCAPE_FRAMES=4 and v=15. Required: after 4 frames x frozen, y falls by 15 per frame until v>y, then `done` with `escaped`=1; a `start` during the sequence is ignored.
- Reset mid-FALL. Required: all outputs back to reset values next cycle; no `done`.

Source files
------------

// File: rtl/duck_pkg.sv
// duck_pkg: shared types and default constants for the duck flight controller.
//   duck_state_t  - flight sequence states
//   DUCK_*        - default screen limits and speeds used as parameter defaults
package duck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLY,
        ST_HIT_HOLD,
        ST_FALL,
        ST_ESCAPE,
        ST_DONE
    } duck_state_t;

    localparam int DUCK_X_MAX         = 1024;
    localparam int DUCK_Y_FLOOR       = 600;
    localparam int DUCK_DEFAULT_V_SPD = 15;
    localparam int DUCK_FALL_SPD      = 8;

endpackage

// File: rtl/duck_axis_step.sv
// duck_axis_step: one-axis bounce step, purely combinational.
//   pos     - current position
//   spd     - step size in pixels
//   dir     - 1 = moving toward larger coordinates, 0 = toward zero
//   limit   - upper bound of the axis (lower bound is 0)
//   pos_nxt - position after the step, clamped to [0, limit]
//   dir_nxt - direction after the step, flipped when a bound was crossed
module duck_axis_step #(
    parameter int POS_W = 11,
    parameter int SPD_W = 5
) (
    input  logic [POS_W-1:0] pos,
    input  logic [SPD_W-1:0] spd,
    input  logic             dir,
    input  logic [POS_W-1:0] limit,
    output logic [POS_W-1:0] pos_nxt,
    output logic             dir_nxt
);

    // One extra bit so pos+spd cannot wrap before the limit compare.
    logic [POS_W:0] pos_ext;
    logic [POS_W:0] spd_ext;
    logic [POS_W:0] sum;

    assign pos_ext = {1'b0, pos};
    assign spd_ext = {{(POS_W + 1 - SPD_W){1'b0}}, spd};
    assign sum     = pos_ext + spd_ext;

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (dir) begin
            if (sum > {1'b0, limit}) begin
                pos_nxt = limit;
                dir_nxt = 1'b0;
            end else begin
                pos_nxt = sum[POS_W-1:0];
            end
        end else begin
            if (spd_ext > pos_ext) begin
                pos_nxt = '0;
                dir_nxt = 1'b1;
            end else begin
                pos_nxt = pos - spd_ext[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/duck_motion.sv
// duck_motion: flight controller for one on-screen duck.
//   clk, rst                  - clock, synchronous active-high reset
//   new_frame                 - one-cycle pulse per video frame
//   start                     - launch request (IDLE only)
//   duck_direction            - initial horizontal direction, 1 = right
//   duck_v_spd, duck_h_spd    - vertical / horizontal speed (pixels/frame)
//   duck_start_x              - launch x
//   hit                       - one-cycle pulse: duck was shot
//   duck_x, duck_y            - registered sprite position
//   duck_show, duck_hit       - sprite visible, hit pose
//   duck_flap                 - wing pose
//   done                      - one-cycle pulse at end of sequence
//   escaped                   - 1 if the last sequence ended by escape
module duck_motion
    import duck_pkg::*;
#(
    parameter int X_MAX           = DUCK_X_MAX,
    parameter int Y_FLOOR         = DUCK_Y_FLOOR,
    parameter int POS_W           = 11,
    parameter int SPD_W           = 5,
    parameter int DEFAULT_V_SPD   = DUCK_DEFAULT_V_SPD,
    parameter int FALL_SPD        = DUCK_FALL_SPD,
    parameter int HIT_HOLD_FRAMES = 30,
    parameter int ESCAPE_FRAMES   = 600,
    parameter int FLAP_FRAMES     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_frame,
    input  logic             start,
    input  logic             duck_direction,
    input  logic [SPD_W-1:0] duck_v_spd,
    input  logic [SPD_W-1:0] duck_h_spd,
    input  logic [POS_W-1:0] duck_start_x,
    input  logic             hit,
    output logic [POS_W-1:0] duck_x,
    output logic [POS_W-1:0] duck_y,
    output logic             duck_show,
    output logic             duck_hit,
    output logic             duck_flap,
    output logic             done,
    output logic             escaped
);

    localparam int CNT_MAX = (ESCAPE_FRAMES > HIT_HOLD_FRAMES) ? ESCAPE_FRAMES : HIT_HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLAP_W  = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

    localparam logic [POS_W-1:0]  X_LIM     = POS_W'(X_MAX - 1);
    localparam logic [POS_W-1:0]  Y_LIM     = POS_W'(Y_FLOOR);
    localparam logic [SPD_W-1:0]  V_DEF     = SPD_W'(DEFAULT_V_SPD);
    localparam logic [SPD_W-1:0]  F_SPD     = SPD_W'(FALL_SPD);
    localparam logic [CNT_W-1:0]  ESC_CNT   = CNT_W'(ESCAPE_FRAMES);
    localparam logic [CNT_W-1:0]  HOLD_CNT  = CNT_W'(HIT_HOLD_FRAMES);
    localparam logic [FLAP_W-1:0] FLAP_LAST = FLAP_W'(FLAP_FRAMES - 1);

    duck_state_t       state;
    logic [SPD_W-1:0]  h_spd;
    logic [SPD_W-1:0]  v_spd;
    logic              dir_x;
    logic              dir_down;
    logic [CNT_W-1:0]  frame_cnt;
    logic [FLAP_W-1:0] flap_cnt;

    logic [CNT_W-1:0]  cnt_inc;
    logic              flap_wrap;
    logic [POS_W-1:0]  x_nxt;
    logic              dir_x_nxt;
    logic [SPD_W-1:0]  y_spd;
    logic              y_dir;
    logic [POS_W-1:0]  y_nxt;
    logic              dir_y_nxt;

    assign cnt_inc   = frame_cnt + CNT_W'(1);
    assign flap_wrap = (flap_cnt == FLAP_LAST);

    // The y stepper is shared: FALL forces the fall speed downward, ESCAPE
    // forces upward travel at the flight speed.
    always_comb begin
        y_spd = v_spd;
        y_dir = dir_down;
        if (state == ST_FALL) begin
            y_spd = F_SPD;
            y_dir = 1'b1;
        end else if (state == ST_ESCAPE) begin
            y_dir = 1'b0;
        end
    end

    duck_axis_step #(.POS_W(POS_W), .SPD_W(SPD_W)) u_step_x (
        .pos     (duck_x),
        .spd     (h_spd),
        .dir     (dir_x),
        .limit   (X_LIM),
        .pos_nxt (x_nxt),
        .dir_nxt (dir_x_nxt)
    );

    duck_axis_step #(.POS_W(POS_W), .SPD_W(SPD_W)) u_step_y (
        .pos     (duck_y),
        .spd     (y_spd),
        .dir     (y_dir),
        .limit   (Y_LIM),
        .pos_nxt (y_nxt),
        .dir_nxt (dir_y_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            h_spd     <= '0;
            v_spd     <= '0;
            dir_x     <= 1'b0;
            dir_down  <= 1'b0;
            frame_cnt <= '0;
            flap_cnt  <= '0;
            duck_x    <= '0;
            duck_y    <= '0;
            duck_show <= 1'b0;
            duck_hit  <= 1'b0;
            duck_flap <= 1'b0;
            done      <= 1'b0;
            escaped   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_FLY;
                        h_spd     <= duck_h_spd;
                        v_spd     <= (duck_v_spd == '0) ? V_DEF : duck_v_spd;
                        dir_x     <= duck_direction;
                        dir_down  <= 1'b0;
                        duck_x    <= (duck_start_x > X_LIM) ? X_LIM : duck_start_x;
                        duck_y    <= Y_LIM;
                        duck_show <= 1'b1;
                        duck_hit  <= 1'b0;
                        duck_flap <= 1'b0;
                        escaped   <= 1'b0;
                        frame_cnt <= '0;
                        flap_cnt  <= '0;
                    end
                end
                ST_FLY: begin
                    if (hit) begin
                        state     <= ST_HIT_HOLD;
                        frame_cnt <= '0;
                        duck_hit  <= 1'b1;
                    end else if (new_frame) begin
                        duck_x    <= x_nxt;
                        dir_x     <= dir_x_nxt;
                        duck_y    <= y_nxt;
                        dir_down  <= dir_y_nxt;
                        frame_cnt <= cnt_inc;
                        flap_cnt  <= flap_wrap ? '0 : flap_cnt + FLAP_W'(1);
                        duck_flap <= duck_flap ^ flap_wrap;
                        if (cnt_inc == ESC_CNT) state <= ST_ESCAPE;
                    end
                end
                ST_ESCAPE: begin
                    if (hit) begin
                        state     <= ST_HIT_HOLD;
                        frame_cnt <= '0;
                        duck_hit  <= 1'b1;
                    end else if (new_frame) begin
                        flap_cnt  <= flap_wrap ? '0 : flap_cnt + FLAP_W'(1);
                        duck_flap <= duck_flap ^ flap_wrap;
                        // Upward step flips direction exactly when v > y:
                        // the duck has left the top of the screen.
                        if (dir_y_nxt) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            duck_show <= 1'b0;
                            escaped   <= 1'b1;
                        end else begin
                            duck_y <= y_nxt;
                        end
                    end
                end
                ST_HIT_HOLD: begin
                    if (new_frame) begin
                        frame_cnt <= cnt_inc;
                        if (cnt_inc == HOLD_CNT) state <= ST_FALL;
                    end
                end
                ST_FALL: begin
                    if (new_frame) begin
                        duck_y <= y_nxt;
                        // Clamped step lands on the floor when y+FALL_SPD >= floor.
                        if (y_nxt == Y_LIM) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            duck_show <= 1'b0;
                            duck_hit  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duck_motion.sv
// tb_duck_motion: randomized and directed bench for duck_motion with a
// behavioural reference model of the flight sequence.
module tb_duck_motion;

    localparam int XM = 1024;
    localparam int YF = 600;
    localparam int PW = 11;
    localparam int SW = 5;
    localparam int DV = 15;
    localparam int FS = 8;
    localparam int HH = 30;
    localparam int EF = 64;
    localparam int FF = 8;

    localparam int P_IDLE = 0;
    localparam int P_FLY  = 1;
    localparam int P_HOLD = 2;
    localparam int P_FALL = 3;
    localparam int P_ESC  = 4;
    localparam int P_DONE = 5;

    logic          clk;
    logic          rst;
    logic          new_frame;
    logic          start;
    logic          duck_direction;
    logic [SW-1:0] duck_v_spd;
    logic [SW-1:0] duck_h_spd;
    logic [PW-1:0] duck_start_x;
    logic          hit;
    logic [PW-1:0] duck_x;
    logic [PW-1:0] duck_y;
    logic          duck_show;
    logic          duck_hit;
    logic          duck_flap;
    logic          done;
    logic          escaped;

    duck_motion #(
        .X_MAX(XM), .Y_FLOOR(YF), .POS_W(PW), .SPD_W(SW),
        .DEFAULT_V_SPD(DV), .FALL_SPD(FS), .HIT_HOLD_FRAMES(HH),
        .ESCAPE_FRAMES(EF), .FLAP_FRAMES(FF)
    ) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
        .duck_direction(duck_direction), .duck_v_spd(duck_v_spd),
        .duck_h_spd(duck_h_spd), .duck_start_x(duck_start_x), .hit(hit),
        .duck_x(duck_x), .duck_y(duck_y), .duck_show(duck_show),
        .duck_hit(duck_hit), .duck_flap(duck_flap), .done(done),
        .escaped(escaped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_ph, m_x, m_y, m_right, m_down, m_h, m_v;
    int m_fly, m_hold_left, m_anim;
    int m_show, m_hit, m_flap, m_done, m_esc;

    task automatic animate();
        m_anim++;
        if (m_anim % FF == 0) m_flap = 1 - m_flap;
    endtask

    task automatic model_step();
        if (rst) begin
            m_ph = P_IDLE; m_x = 0; m_y = 0; m_right = 0; m_down = 0;
            m_h = 0; m_v = 0; m_fly = 0; m_hold_left = 0; m_anim = 0;
            m_show = 0; m_hit = 0; m_flap = 0; m_done = 0; m_esc = 0;
        end else begin
            m_done = 0;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_ph = P_FLY;
                    m_h = int'(duck_h_spd);
                    m_v = (duck_v_spd == 0) ? DV : int'(duck_v_spd);
                    m_right = duck_direction;
                    m_down = 0;
                    m_x = (int'(duck_start_x) > XM - 1) ? XM - 1 : int'(duck_start_x);
                    m_y = YF;
                    m_show = 1; m_hit = 0; m_esc = 0; m_flap = 0;
                    m_fly = 0; m_anim = 0;
                end
                P_FLY: begin
                    if (hit) begin
                        m_ph = P_HOLD; m_hold_left = HH; m_hit = 1;
                    end else if (new_frame) begin
                        if (m_right != 0) begin
                            if (m_x + m_h > XM - 1) begin m_x = XM - 1; m_right = 0; end
                            else m_x = m_x + m_h;
                        end else begin
                            if (m_h > m_x) begin m_x = 0; m_right = 1; end
                            else m_x = m_x - m_h;
                        end
                        if (m_down == 0) begin
                            if (m_v > m_y) begin m_y = 0; m_down = 1; end
                            else m_y = m_y - m_v;
                        end else begin
                            if (m_y + m_v > YF) begin m_y = YF; m_down = 0; end
                            else m_y = m_y + m_v;
                        end
                        m_fly++;
                        animate();
                        if (m_fly == EF) m_ph = P_ESC;
                    end
                end
                P_ESC: begin
                    if (hit) begin
                        m_ph = P_HOLD; m_hold_left = HH; m_hit = 1;
                    end else if (new_frame) begin
                        animate();
                        if (m_v > m_y) begin
                            m_ph = P_DONE; m_done = 1; m_show = 0; m_esc = 1;
                        end else begin
                            m_y = m_y - m_v;
                        end
                    end
                end
                P_HOLD: if (new_frame) begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_ph = P_FALL;
                end
                P_FALL: if (new_frame) begin
                    if (m_y + FS >= YF) begin
                        m_y = YF; m_ph = P_DONE; m_done = 1; m_show = 0; m_hit = 0;
                    end else begin
                        m_y = m_y + FS;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("duck_x", duck_x, m_x);
        check("duck_y", duck_y, m_y);
        check("duck_show", duck_show, m_show);
        check("duck_hit", duck_hit, m_hit);
        check("duck_flap", duck_flap, m_flap);
        check("done", done, m_done);
        check("escaped", escaped, m_esc);
    endtask

    task automatic cycle(input bit nf, input bit st, input bit ht);
        new_frame = nf; start = st; hit = ht;
        model_step();
        @(posedge clk); #1;
        compare_all();
        new_frame = 1'b0; start = 1'b0; hit = 1'b0;
    endtask

    task automatic frame(input bit ht);
        cycle(1'b1, 1'b0, ht);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic launch(input int sx, input int h, input int v, input bit d);
        duck_start_x = PW'(sx); duck_h_spd = SW'(h); duck_v_spd = SW'(v); duck_direction = d;
        cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic finish_seq();
        int n = 0;
        while (m_ph != P_IDLE && n < 2000) begin
            frame(1'b0);
            n++;
        end
        check("seq_end_budget", (n < 2000), 1);
        check("seq_end_show", duck_show, 0);
    endtask

    initial begin
        rst = 1'b1; new_frame = 1'b0; start = 1'b0; hit = 1'b0;
        duck_direction = 1'b0; duck_v_spd = '0; duck_h_spd = '0; duck_start_x = '0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("rst_x", duck_x, 0);
        check("rst_y", duck_y, 0);
        check("rst_show", duck_show, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        cycle(0, 0, 0);

        // Launch, one move, then hit together with a frame
        launch(100, 4, 0, 1'b1);
        check("launch_x", duck_x, 100);
        check("launch_y", duck_y, 600);
        check("launch_show", duck_show, 1);
        frame(1'b0);
        check("move_x", duck_x, 104);
        check("move_y", duck_y, 585);
        frame(1'b1);
        check("hit_nomove_x", duck_x, 104);
        check("hit_nomove_y", duck_y, 585);
        check("hit_pose", duck_hit, 1);
        for (int i = 0; i < HH; i++) frame(1'b0);
        check("hold_frozen_y", duck_y, 585);
        frame(1'b0);
        check("fall_step_y", duck_y, 593);
        finish_seq();
        check("fall_floor_y", duck_y, 600);
        check("fall_escaped", escaped, 0);

        // Right wall
        launch(1020, 8, 1, 1'b1);
        frame(1'b0);
        check("rwall_x", duck_x, 1023);
        frame(1'b0);
        check("rwall_back_x", duck_x, 1015);
        frame(1'b1);
        finish_seq();

        // Left wall
        launch(3, 8, 1, 1'b0);
        frame(1'b0);
        check("lwall_x", duck_x, 0);
        frame(1'b0);
        check("lwall_back_x", duck_x, 8);
        frame(1'b1);
        finish_seq();

        // Top and floor bounce, then escape with an ignored start
        launch(2000, 0, 29, 1'b1);
        check("clamp_x", duck_x, 1023);
        for (int i = 0; i < 20; i++) frame(1'b0);
        check("top_pre_y", duck_y, 20);
        frame(1'b0);
        check("top_bounce_y", duck_y, 0);
        for (int i = 0; i < 20; i++) frame(1'b0);
        check("floor_pre_y", duck_y, 580);
        frame(1'b0);
        check("floor_bounce_y", duck_y, 600);
        begin
            int n = 0;
            while (m_ph != P_ESC && n < 200) begin frame(1'b0); n++; end
            check("reach_escape", (m_ph == P_ESC), 1);
        end
        duck_start_x = PW'(5);
        cycle(0, 1, 0);
        check("start_ignored_x", duck_x, 1023);
        finish_seq();
        check("escape_flag", escaped, 1);

        // Reset in the middle of a fall
        launch(200, 3, 5, 1'b1);
        for (int i = 0; i < 5; i++) frame(1'b0);
        frame(1'b1);
        for (int i = 0; i < HH; i++) frame(1'b0);
        frame(1'b0);
        check("midfall_y", duck_y, 583);
        rst = 1'b1;
        cycle(0, 0, 0);
        rst = 1'b0;
        check("rstfall_x", duck_x, 0);
        check("rstfall_y", duck_y, 0);
        check("rstfall_hit", duck_hit, 0);
        check("rstfall_done", done, 0);
        frame(1'b0);
        check("rstfall_nodone", done, 0);

        // Randomized traffic
        for (int c = 0; c < 25000; c++) begin
            rst = ($urandom % 4000 == 0);
            duck_direction = 1'($urandom);
            duck_v_spd = SW'($urandom);
            duck_h_spd = SW'($urandom);
            duck_start_x = PW'($urandom_range(0, 2047));
            cycle(($urandom % 3 == 0), ($urandom % 16 == 0), ($urandom % 60 == 0));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
